// File: rtl/fd_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package fd_queue_pkg;

    localparam int FDQ_XLEN = 32;

    localparam logic [FDQ_XLEN-1:0] FDQ_NOP_RV  = 32'h00000013;
    localparam logic [FDQ_XLEN-1:0] FDQ_NOP_ARM = 32'hE1A00000;

    typedef struct packed {
        logic                arm;
        logic [FDQ_XLEN-1:0] instr;
        logic [FDQ_XLEN-1:0] pc;
        logic [FDQ_XLEN-1:0] pcplus4;
    } fdq_entry_t;

endpackage

// File: rtl/fdq_mem.sv
// Entry storage for fd_queue: DEPTH registers, one write port, one combinational read port.
module fdq_mem
    import fd_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  fdq_entry_t       wdata,
    input  logic [AW-1:0]    raddr,
    output fdq_entry_t       rdata
);

    // Data-only storage; validity is tracked by the queue's count, so no reset.
    fdq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fd_queue.sv
// Fetch-to-decode instruction queue: circular buffer of fetched instructions with
// mode-correct NOP substitution when decode finds it empty.
module fd_queue
    import fd_queue_pkg::*;
#(
    parameter int               XLEN    = FDQ_XLEN,
    parameter int               DEPTH   = 4,
    parameter logic [XLEN-1:0]  NOP_RV  = FDQ_NOP_RV,
    parameter logic [XLEN-1:0]  NOP_ARM = FDQ_NOP_ARM,
    parameter int               AW      = $clog2(DEPTH),
    parameter int               CW      = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RDF,
    input  logic [XLEN-1:0] PCF,
    input  logic [XLEN-1:0] PCPlus4F,
    input  logic            armF,
    input  logic            ValidF,
    output logic            ReadyF,
    input  logic            StallD,
    input  logic            FlushD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            armD,
    output logic            ValidD,
    output logic [CW-1:0]   CountD
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_arm_q, last_arm_d;

    logic       push, pop;
    fdq_entry_t wr_entry, head;

    assign ReadyF = (count_q != CW'(DEPTH));
    assign ValidD = (count_q != '0);

    // Flush wins over stall and over a same-cycle push.
    assign push = ValidF & ReadyF & ~FlushD;
    assign pop  = ValidD & ~StallD & ~FlushD;

    assign wr_entry = '{arm: armF, instr: RDF, pc: PCF, pcplus4: PCPlus4F};

    fdq_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_arm_d = last_arm_q;
        if (FlushD) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                last_arm_d = head.arm;
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_arm_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_arm_q <= last_arm_d;
        end
    end

    // When empty, decode sees a bubble in the mode of the last instruction it consumed.
    assign armD     = ValidD ? head.arm     : last_arm_q;
    assign InstrD   = ValidD ? head.instr   : (last_arm_q ? NOP_ARM : NOP_RV);
    assign PCD      = ValidD ? head.pc      : '0;
    assign PCPlus4D = ValidD ? head.pcplus4 : '0;
    assign CountD   = count_q;

endmodule
